// File: rtl/serial_add_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | serial_add_unit                                                             |
// | Bit-serial LSB-first adder with start/done handshake and a serial bit tap.  |
// | Optional: define SERIAL_ADD_SAT_EN to saturate the word result on overflow. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module serial_add_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out,
   output logic             ser_valid,
   output logic             ser_sum,
   output logic             ser_cout
);

   localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_sha;
   logic [WIDTH-1:0]   r_shb;
   logic [WIDTH-2:0]   r_res;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_c;

   logic               w_run;
   logic               w_a;
   logic               w_b;
   logic               w_p;
   logic               w_s;
   logic               w_cn;
   logic [WIDTH-1:0]   w_sum_next;

   // Full add built from two half-add terms: p = a^b, then s = p^c.
   assign w_run      = (r_state == S_RUN);
   assign w_a        = r_sha[0];
   assign w_b        = r_shb[0];
   assign w_p        = w_a ^ w_b;
   assign w_s        = w_p ^ r_c;
   assign w_cn       = (w_a & w_b) | (r_c & w_p);
   assign w_sum_next = {w_s, r_res};

   assign busy       = w_run;
   assign done       = (r_state == S_DONE);
   assign ser_valid  = w_run;
   assign ser_sum    = w_run & w_s;
   assign ser_cout   = w_run & w_cn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_sha    <= '0;
         r_shb    <= '0;
         r_res    <= '0;
         r_cnt    <= '0;
         r_c      <= 1'b0;
         sum_out  <= '0;
         cout_out <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_sha   <= a_in;
                  r_shb   <= b_in;
                  r_res   <= '0;
                  r_cnt   <= '0;
                  r_c     <= 1'b0;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_sha <= r_sha >> 1;
               r_shb <= r_shb >> 1;
               r_c   <= w_cn;
               // Result fills from the MSB end; after WIDTH shifts bit 0 lands at index 0.
               r_res <= w_sum_next[WIDTH-1:1];
               if (r_cnt == c_LAST) begin
                  r_state  <= S_DONE;
                  cout_out <= w_cn;
`ifdef SERIAL_ADD_SAT_EN
                  sum_out  <= w_cn ? {WIDTH{1'b1}} : w_sum_next;
`else
                  sum_out  <= w_sum_next;
`endif
               end else begin
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_serial_add_unit                                                          |
// | Table vectors, corner sequences and random sweeps at WIDTH=8 and WIDTH=16.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_serial_add_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start;
   logic [7:0] a_in, b_in, sum_out;
   logic       busy, done, cout_out, ser_valid, ser_sum, ser_cout;

   serial_add_unit #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
      .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out),
      .ser_valid(ser_valid), .ser_sum(ser_sum), .ser_cout(ser_cout)
   );

   logic        start16;
   logic [15:0] a16, b16, sum16;
   logic        busy16, done16, cout16, sv16, ss16, sc16;

   serial_add_unit #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .a_in(a16), .b_in(b16),
      .busy(busy16), .done(done16), .sum_out(sum16), .cout_out(cout16),
      .ser_valid(sv16), .ser_sum(ss16), .ser_cout(sc16)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   vec_t sb_q[$];
   vec_t tbl[7];
   int   n_vec = 0;
   int   n_bad = 0;
   int   done_cnt = 0;
   int   mon_bit = 0;
   logic mon_c = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Saturation only changes the word result, never the serial stream.
   function automatic logic [7:0] fix8(input logic [7:0] s, input logic c);
`ifdef SERIAL_ADD_SAT_EN
      return c ? 8'hFF : s;
`else
      return s;
`endif
   endfunction

   function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b);
      vec_t       v;
      logic [8:0] t;
      t      = {1'b0, a} + {1'b0, b};
      v.a    = a;
      v.b    = b;
      v.cout = t[8];
      v.sum  = fix8(t[7:0], t[8]);
      return v;
   endfunction

   // Scoreboard monitor: serial bits against a bench-side full add, words on done.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ser_valid) begin
            if (sb_q.size() == 0) begin
               check("ser_orphan", 1, 0);
            end else begin
               logic ea, eb, es, ec;
               if (mon_bit == 0) mon_c = 1'b0;
               ea = sb_q[0].a[mon_bit];
               eb = sb_q[0].b[mon_bit];
               es = ea ^ eb ^ mon_c;
               ec = (ea & eb) | (mon_c & (ea ^ eb));
               check("ser_sum", 32'(ser_sum), 32'(es));
               check("ser_cout", 32'(ser_cout), 32'(ec));
               mon_c   = ec;
               mon_bit = (mon_bit == 7) ? 0 : mon_bit + 1;
            end
         end
         if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
               check("spurious_done", 1, 0);
            end else begin
               vec_t v;
               v = sb_q.pop_front();
               check("sum_out", 32'(sum_out), 32'(v.sum));
               check("cout_out", 32'(cout_out), 32'(v.cout));
            end
         end
      end
   end

   task automatic issue(input vec_t v);
      int guard = 0;
      while (busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      a_in  = v.a;
      b_in  = v.b;
      start = 1'b1;
      sb_q.push_back(v);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   task automatic run16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] t;
      logic [15:0] es16;
      logic        c, es, ec;
      int          bad, k, cyc;
      t = {1'b0, a} + {1'b0, b};
`ifdef SERIAL_ADD_SAT_EN
      es16 = t[16] ? 16'hFFFF : t[15:0];
`else
      es16 = t[15:0];
`endif
      a16 = a; b16 = b; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      c = 1'b0; bad = 0; k = 0; cyc = 0;
      while (!done16 && cyc < 40) begin
         if (sv16) begin
            if (k < 16) begin
               es = a[k] ^ b[k] ^ c;
               ec = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
               if (ss16 !== es || sc16 !== ec) bad++;
               c = ec;
            end
            k++;
         end
         @(negedge clk);
         cyc++;
      end
      check("w16_done", 32'(done16), 1);
      check("w16_sum", 32'(sum16), 32'(es16));
      check("w16_cout", 32'(cout16), 32'(t[16]));
      check("w16_ser_bad", 32'(bad), 0);
      check("w16_ser_bits", 32'(k), 16);
      @(negedge clk);
   endtask

   initial begin
      int lat, c2, dc;
      vec_t v;
      start = 1'b0; a_in = '0; b_in = '0;
      start16 = 1'b0; a16 = '0; b16 = '0;

      tbl[0] = '{8'h0F, 8'h01, 8'h10, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
      tbl[2] = '{8'h55, 8'hAA, 8'hFF, 1'b0};
      tbl[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
      tbl[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
      tbl[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
      tbl[6] = '{8'h7F, 8'h01, 8'h80, 1'b0};
      for (int i = 0; i < 7; i++) tbl[i].sum = fix8(tbl[i].sum, tbl[i].cout);

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_sum", 32'(sum_out), 0);
      check("rst_cout", 32'(cout_out), 0);
      check("rst_ser", 32'({ser_valid, ser_sum, ser_cout}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         issue(tbl[i]);
         wait_done(lat);
         if (i == 0) check("latency", 32'(lat), 8);
         @(negedge clk);
         check("done_pulse", 32'(done), 0);
      end

      // start during RUN must be dropped
      dc = done_cnt;
      issue('{8'h33, 8'h44, 8'h77, 1'b0});
      repeat (3) @(negedge clk);
      a_in = 8'hF0; b_in = 8'hF0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      repeat (4) @(negedge clk);
      check("ignored_start_dones", 32'(done_cnt - dc), 1);
      check("ignored_start_idle", 32'(busy), 0);

      // back-to-back with start held through DONE
      a_in = 8'h55; b_in = 8'hAA; start = 1'b1;
      sb_q.push_back('{8'h55, 8'hAA, 8'hFF, 1'b0});
      @(negedge clk);
      wait_done(lat);
      sb_q.push_back('{8'h55, 8'hAA, 8'hFF, 1'b0});
      @(negedge clk);
      start = 1'b0;
      check("b2b_no_idle", 32'(busy), 1);
      wait_done(c2);
      check("b2b_gap", 32'(c2 + 1), 9);
      @(negedge clk);

      // async reset at bit 5
      issue('{8'h0F, 8'hF0, 8'hFF, 1'b0});
      repeat (5) @(negedge clk);
      dc = done_cnt;
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_ser", 32'({ser_valid, ser_sum, ser_cout}), 0);
      check("mid_rst_sum", 32'(sum_out), 0);
      check("mid_rst_cout", 32'({done, cout_out}), 0);
      sb_q.delete();
      mon_bit = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_no_done", 32'(done_cnt - dc), 0);
      issue('{8'h01, 8'h01, 8'h02, 1'b0});
      wait_done(lat);
      @(negedge clk);

      for (int i = 0; i < 1000; i++) begin
         v = mk(8'($urandom), 8'($urandom));
         issue(v);
         wait_done(lat);
         @(negedge clk);
      end
      check("sb_drained", 32'(sb_q.size()), 0);

      run16(16'hFFFF, 16'h0001);
      run16(16'h00FF, 16'h0001);
      for (int i = 0; i < 1000; i++) run16(16'($urandom), 16'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
